shift_seq_nbit: RTL and testbench

Parametrised sequential shift engine. It is the successor to the single-step load/store/shift register. It loads an N-bit word, then performs a multi-cycle shift or rotate by a programmable amount, one bit per clock, under a start/busy/done handshake. It sits beside datapath registers where a serial multiplier or divider needs controlled multi-bit shifts without a barrel shifter.

---
 rtl/shift_seq_nbit_if.sv | 35 +++
 rtl/shift_seq_nbit.sv | 138 +++++++++++++
 tb/tb_shift_seq_nbit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_nbit_if.sv
// Handshake/data bundle for shift_seq_nbit: command in, register contents and status out.
// The abort input exists only when SHIFT_SEQ_ABORT_EN is defined.
interface shift_seq_nbit_if #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) ();
  logic             start;
  logic [2:0]       op;
  logic [CNT_W-1:0] amt;
  logic [N-1:0]     din;
  logic             sin;
  logic [N-1:0]     dout;
  logic             sout;
  logic             busy;
  logic             done;
`ifdef SHIFT_SEQ_ABORT_EN
  logic             abort;
`endif

  modport master (
    output start, op, amt, din, sin,
`ifdef SHIFT_SEQ_ABORT_EN
    output abort,
`endif
    input  dout, sout, busy, done
  );

  modport slave (
    input  start, op, amt, din, sin,
`ifdef SHIFT_SEQ_ABORT_EN
    input  abort,
`endif
    output dout, sout, busy, done
  );
endinterface

// File: rtl/shift_seq_nbit.sv
// Sequential shift/rotate engine: loads a word, then one bit step per clock for amt cycles (amt+1 busy cycles).
// start is ignored while busy; optional SHIFT_SEQ_ABORT_EN adds an abort input that cancels SHIFT without done.
module shift_seq_nbit #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           clr,
  shift_seq_nbit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  state_t           state_q, state_d;
  logic [N-1:0]     dout_q, dout_d;
  logic             sout_q, sout_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [N-1:0]     step_dat;
  logic             step_out;

  // One-bit step on the current contents; HOLD codes leave both unchanged.
  always_comb begin
    step_dat = dout_q;
    step_out = sout_q;
    case (op_q)
      OP_LSL: begin
        step_dat = {dout_q[N-2:0], bus.sin};
        step_out = dout_q[N-1];
      end
      OP_LSR: begin
        step_dat = {bus.sin, dout_q[N-1:1]};
        step_out = dout_q[0];
      end
      OP_ASR: begin
        step_dat = {dout_q[N-1], dout_q[N-1:1]};
        step_out = dout_q[0];
      end
      OP_ROL: begin
        step_dat = {dout_q[N-2:0], dout_q[N-1]};
        step_out = dout_q[N-1];
      end
      OP_ROR: begin
        step_dat = {dout_q[0], dout_q[N-1:1]};
        step_out = dout_q[0];
      end
      default: begin
        step_dat = dout_q;
        step_out = sout_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    sout_d  = sout_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dout_d  = bus.din;
          op_d    = bus.op;
          cnt_d   = bus.amt;
          state_d = (bus.amt != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
`ifdef SHIFT_SEQ_ABORT_EN
        if (bus.abort) begin
          // Partial result of the last completed step is kept as-is.
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          dout_d = step_dat;
          sout_d = step_out;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
`else
        dout_d = step_dat;
        sout_d = step_out;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Status is registered alongside the state it describes.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      dout_q  <= '0;
      sout_q  <= 1'b0;
      op_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      sout_q  <= sout_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.sout = sout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_shift_seq_nbit.sv
// Directed bench for shift_seq_nbit (N=8, CNT_W=4): table of operations plus hand sequences
// for start-while-busy, asynchronous clr mid-shift and, when SHIFT_SEQ_ABORT_EN is defined, abort.
module tb_shift_seq_nbit;

  localparam int N     = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic clr;

  shift_seq_nbit_if #(.N(N), .CNT_W(CNT_W)) ifc ();

  shift_seq_nbit #(.N(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       op;
    logic [CNT_W-1:0] amt;
    logic [N-1:0]     din;
    logic             sin;
    logic [N-1:0]     exp_dout;
    logic             exp_sout;
  } vec_t;

  vec_t vecs [7];
  int   n_vec;
  int   n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ifc.start = 1'b0;
    ifc.op    = 3'd0;
    ifc.amt   = '0;
    ifc.din   = '0;
    ifc.sin   = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
    ifc.abort = 1'b0;
`endif
  endtask

  // Issue one operation and watch it until busy falls; cycle index 1 is the first cycle after the start edge.
  task automatic run_op(input vec_t v, output int done_at, output int done_cnt,
                        output int busy_cnt, output int sign_bad);
    int i;
    done_at  = -1;
    done_cnt = 0;
    busy_cnt = 0;
    sign_bad = 0;
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.op    = v.op;
    ifc.amt   = v.amt;
    ifc.din   = v.din;
    ifc.sin   = v.sin;
    i = 0;
    while (i < 40) begin
      @(negedge clk);
      i++;
      ifc.start = 1'b0;
      if (ifc.busy) busy_cnt++;
      if (ifc.done) begin
        done_cnt++;
        done_at = i;
      end
      if (v.op == 3'b010 && ifc.busy && ifc.dout[N-1] !== v.din[N-1]) sign_bad++;
      if (!ifc.busy) break;
    end
    if (i >= 40) $display("FAIL run_op timeout: busy still %0b after %0d cycles, expected low", ifc.busy, i);
  endtask

  initial begin
    int done_at, done_cnt, busy_cnt, sign_bad;
    vec_t v;
    n_vec = 0;
    n_bad = 0;

    //              op      amt    din    sin   dout   sout
    vecs[0] = '{3'b000, 4'd3, 8'h96, 1'b0, 8'hB0, 1'b0};  // LSL
    vecs[1] = '{3'b010, 4'd3, 8'hA4, 1'b0, 8'hF4, 1'b1};  // ASR
    vecs[2] = '{3'b100, 4'd8, 8'h81, 1'b0, 8'h81, 1'b1};  // ROR full turn
    vecs[3] = '{3'b000, 4'd0, 8'h5A, 1'b0, 8'h5A, 1'b1};  // amt=0, sout retained
    vecs[4] = '{3'b001, 4'd4, 8'h00, 1'b1, 8'hF0, 1'b0};  // LSR with sin=1
    vecs[5] = '{3'b101, 4'd5, 8'h3C, 1'b1, 8'h3C, 1'b0};  // HOLD as delay
    vecs[6] = '{3'b011, 4'd1, 8'h81, 1'b0, 8'h03, 1'b1};  // ROL single step

    drive_idle();
    clr = 1'b1;
    @(negedge clk);
    chk("reset dout", 32'(ifc.dout), 32'h0);
    chk("reset sout", 32'(ifc.sout), 32'h0);
    chk("reset busy", 32'(ifc.busy), 32'h0);
    chk("reset done", 32'(ifc.done), 32'h0);
    clr = 1'b0;

    for (int k = 0; k < 7; k++) begin
      run_op(vecs[k], done_at, done_cnt, busy_cnt, sign_bad);
      chk($sformatf("v%0d dout", k), 32'(ifc.dout), 32'(vecs[k].exp_dout));
      chk($sformatf("v%0d sout", k), 32'(ifc.sout), 32'(vecs[k].exp_sout));
      chk($sformatf("v%0d done_at", k), 32'(done_at), 32'(vecs[k].amt) + 32'd1);
      chk($sformatf("v%0d done_cnt", k), 32'(done_cnt), 32'd1);
      chk($sformatf("v%0d busy_cnt", k), 32'(busy_cnt), 32'(vecs[k].amt) + 32'd1);
      if (vecs[k].op == 3'b010) chk($sformatf("v%0d sign", k), 32'(sign_bad), 32'd0);
    end

    // start re-asserted during SHIFT with a different word must be ignored.
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = 3'b000; ifc.amt = 4'd3; ifc.din = 8'h96; ifc.sin = 1'b0;
    @(negedge clk);
    ifc.start = 1'b0;
    @(negedge clk);
    ifc.start = 1'b1; ifc.din = 8'hFF; ifc.op = 3'b011; ifc.amt = 4'd7;
    @(negedge clk);
    ifc.start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (ifc.done) done_cnt++;
      @(negedge clk);
    end
    chk("busy-start dout", 32'(ifc.dout), 32'hB0);
    chk("busy-start sout", 32'(ifc.sout), 32'h0);
    chk("busy-start done_cnt", 32'(done_cnt), 32'd1);
    chk("busy-start idle", 32'(ifc.busy), 32'h0);

    // Asynchronous clr between edges in the middle of a rotate.
    ifc.start = 1'b1; ifc.op = 3'b011; ifc.amt = 4'd8; ifc.din = 8'h81;
    @(negedge clk);
    ifc.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-clr busy", 32'(ifc.busy), 32'h1);
    chk("pre-clr dout", 32'(ifc.dout), 32'h06);
    #2 clr = 1'b1;
    #1;
    chk("clr dout", 32'(ifc.dout), 32'h0);
    chk("clr sout", 32'(ifc.sout), 32'h0);
    chk("clr busy", 32'(ifc.busy), 32'h0);
    @(negedge clk);
    clr = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ifc.done) done_cnt++;
      if (ifc.busy) busy_cnt++;
    end
    chk("clr no done", 32'(done_cnt), 32'd0);
    chk("clr stays idle", 32'(busy_cnt), 32'd0);

`ifdef SHIFT_SEQ_ABORT_EN
    // Abort on the third SHIFT cycle keeps the two completed rotate steps.
    ifc.start = 1'b1; ifc.op = 3'b011; ifc.amt = 4'd6; ifc.din = 8'h01;
    @(negedge clk);
    ifc.start = 1'b0;
    done_cnt = 0;
    @(negedge clk);
    if (ifc.done) done_cnt++;
    @(negedge clk);
    if (ifc.done) done_cnt++;
    chk("abort pre dout", 32'(ifc.dout), 32'h04);
    ifc.abort = 1'b1;
    @(negedge clk);
    ifc.abort = 1'b0;
    chk("abort dout", 32'(ifc.dout), 32'h04);
    chk("abort busy", 32'(ifc.busy), 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (ifc.done) done_cnt++;
      @(negedge clk);
    end
    chk("abort no done", 32'(done_cnt), 32'd0);
    chk("abort dout hold", 32'(ifc.dout), 32'h04);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
